// File: rtl/fperm_tbl_loader.sv
// Write-side sequencer for the FP permute lookup table: bursts of packed FP words to consecutive wrapping indices.
// Optional read-back verification of each burst is compiled in with `define FPERM_TBL_VERIFY_EN.
module fperm_tbl_loader #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] base_idx,
  input  logic [IDX_W:0]   count,
  input  logic [1:0]       cfg_ptype,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [67:0]      in_data,
  output logic             tbl_write,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [67:0]      tbl_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             tbl_read,
  input  logic [67:0]      rd_data
);

  localparam int unsigned    DEPTH   = 1 << IDX_W;
  localparam logic [IDX_W:0] DEPTH_C = DEPTH[IDX_W:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd3;
`ifdef FPERM_TBL_VERIFY_EN
  localparam logic [1:0] S_VERIFY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [1:0]       ptype_q, ptype_d;
  logic [IDX_W:0]   n_q, n_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [67:0]      data_q, data_d;

  logic             hs;
  logic             tag_ok;
  logic [IDX_W:0]   cnt_clamp;
  logic [IDX_W-1:0] idx_wr;

  // Ready drops as soon as the last word is in, so no extra word slips through.
  assign in_ready  = (state_q == S_LOAD) && (n_q != cnt_q);
  assign hs        = in_valid && in_ready;
  assign tag_ok    = (in_data[67:66] == ptype_q);
  assign cnt_clamp = (count > DEPTH_C) ? DEPTH_C : count;
  assign idx_wr    = base_q + n_q[IDX_W-1:0];

`ifdef FPERM_TBL_VERIFY_EN
  localparam logic [RD_LAT-1:0] PV_LAST = RD_LAT'(1) << (RD_LAT - 1);

  logic [67:0]      shadow_q [DEPTH];
  logic [IDX_W-1:0] widx_q   [DEPTH];
  logic [IDX_W:0]   wcnt_q, wcnt_d;
  logic [IDX_W:0]   k_q, k_d;
  logic             rd_q, rd_d;
  logic [67:0]      rexp_q, rexp_d;
  logic [RD_LAT-1:0] pv_q;
  logic [67:0]      pexp_q [RD_LAT];
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ptype_d = ptype_q;
    n_d     = n_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef FPERM_TBL_VERIFY_EN
    wcnt_d  = wcnt_q;
    k_d     = k_q;
    rd_d    = 1'b0;
    rexp_d  = rexp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_idx;
          cnt_d   = cnt_clamp;
          ptype_d = cfg_ptype;
          err_d   = 1'b0;
          n_d     = '0;
          state_d = (cnt_clamp == '0) ? S_DONE : S_LOAD;
`ifdef FPERM_TBL_VERIFY_EN
          wcnt_d  = '0;
          k_d     = '0;
`endif
        end
      end
      S_LOAD: begin
        if (hs) begin
          n_d = n_q + 1'b1;
          if (tag_ok) begin
            wr_d   = 1'b1;
            idx_d  = idx_wr;
            data_d = in_data;
`ifdef FPERM_TBL_VERIFY_EN
            wcnt_d = wcnt_q + 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (n_q == cnt_q) begin
`ifdef FPERM_TBL_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FPERM_TBL_VERIFY_EN
      S_VERIFY: begin
        if (k_q != wcnt_q) begin
          rd_d   = 1'b1;
          idx_d  = widx_q[k_q[IDX_W-1:0]];
          rexp_d = shadow_q[k_q[IDX_W-1:0]];
          k_d    = k_q + 1'b1;
        end else if (!rd_q && ((pv_q & ~PV_LAST) == '0)) begin
          // Leave when only the final compare remains, so err and done land together.
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef FPERM_TBL_VERIFY_EN
    if (pv_q[RD_LAT-1] && (rd_data != pexp_q[RD_LAT-1])) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      ptype_q <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ptype_q <= ptype_d;
      n_q     <= n_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

`ifdef FPERM_TBL_VERIFY_EN
  // Shadow kept in write order so verification replays writes without scanning skipped slots.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && hs && tag_ok) begin
      shadow_q[wcnt_q[IDX_W-1:0]] <= in_data;
      widx_q[wcnt_q[IDX_W-1:0]]   <= idx_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      k_q    <= '0;
      rd_q   <= 1'b0;
      rexp_q <= '0;
      pv_q   <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      rexp_q  <= rexp_d;
      pv_q[0] <= rd_q;
      for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pexp_q[0] <= rexp_q;
    for (int unsigned i = 1; i < RD_LAT; i++) pexp_q[i] <= pexp_q[i-1];
  end

  assign tbl_read = rd_q;
`else
  logic unused_ok;
  assign unused_ok = ^{rd_data, RD_LAT[0]};
  assign tbl_read  = 1'b0;
`endif

  assign tbl_write = wr_q;
  assign tbl_idx   = idx_q;
  assign tbl_data  = data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_fperm_tbl_loader.sv
// Directed bench for fperm_tbl_loader (default build): bursts, wrap/stall, mismatch, edge counts, reset abort.
module tb_fperm_tbl_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  base_idx;
  logic [3:0]  count;
  logic [1:0]  cfg_ptype;
  logic        in_valid;
  logic        in_ready;
  logic [67:0] in_data;
  logic        tbl_write;
  logic [2:0]  tbl_idx;
  logic [67:0] tbl_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        tbl_read;
  logic [67:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fperm_tbl_loader #(.IDX_W(3), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .count(count),
    .cfg_ptype(cfg_ptype), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tbl_write(tbl_write), .tbl_idx(tbl_idx), .tbl_data(tbl_data), .busy(busy),
    .done(done), .err(err), .tbl_read(tbl_read), .rd_data(rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] ei, input logic [67:0] ed);
    chk_b({tag, "_wr"}, tbl_write, 1'b1);
    chk_i({tag, "_idx"}, tbl_idx, ei);
    chk_v({tag, "_data"}, tbl_data, ed);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, "_in_ready"}, in_ready, 1'b0);
    chk_b({tag, "_wr"}, tbl_write, 1'b0);
    chk_b({tag, "_rd"}, tbl_read, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
    chk_i({tag, "_idx"}, tbl_idx, 3'd0);
    chk_v({tag, "_data"}, tbl_data, 68'd0);
  endtask

  function automatic logic [67:0] mk(input logic [1:0] tag, input int unsigned i);
    return {tag, 2'b01, 32'hC0DE_0000 + i, 32'h5A00_0000 ^ (i * 32'h0000_1111)};
  endfunction

  task automatic do_start(input logic [2:0] b, input logic [3:0] c, input logic [1:0] p);
    base_idx  = b;
    count     = c;
    cfg_ptype = p;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    bit vp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned nw;

    rst = 1'b1; start = 1'b0; base_idx = '0; count = '0; cfg_ptype = '0;
    in_valid = 1'b0; in_data = '0; rd_data = '0;
    tick();
    tick();
    chk_reset_vals("rst_held");
    rst = 1'b0;
    tick();
    chk_reset_vals("rst_rel");

    // Basic burst: base 0, count 3, tag 01, back-to-back
    do_start(3'd0, 4'd3, 2'b01);
    chk_b("basic_busy", busy, 1'b1);
    chk_b("basic_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(2'b01, 10 + i);
      tick();
      chk_wr($sformatf("basic_w%0d", i), 3'(i), mk(2'b01, 10 + i));
    end
    in_valid = 1'b0;
    chk_b("basic_ready_drop", in_ready, 1'b0);
    chk_b("basic_done_early", done, 1'b0);
    tick();
    chk_b("basic_done", done, 1'b1);
    chk_b("basic_done_nowr", tbl_write, 1'b0);
    chk_b("basic_err", err, 1'b0);
    tick();
    chk_b("basic_done_pulse", done, 1'b0);
    chk_b("basic_idle", busy, 1'b0);

    // Wrap and stall: base 6, count 4, valid pattern 1,0,1,1,0,1
    do_start(3'd6, 4'd4, 2'b11);
    nw = 0;
    for (int s = 0; s < 6; s++) begin
      in_valid = vp[s];
      in_data  = mk(2'b11, 100 + nw);
      tick();
      if (vp[s]) begin
        chk_wr($sformatf("wrap_s%0d", s), 3'(6 + nw), mk(2'b11, 100 + nw));
        nw++;
      end else begin
        chk_b($sformatf("wrap_stall%0d_wr", s), tbl_write, 1'b0);
        chk_i($sformatf("wrap_stall%0d_idx", s), tbl_idx, 3'(6 + nw - 1));
        chk_v($sformatf("wrap_stall%0d_data", s), tbl_data, mk(2'b11, 100 + nw - 1));
      end
    end
    in_valid = 1'b0;
    chk_b("wrap_ready_drop", in_ready, 1'b0);
    tick();
    chk_b("wrap_done", done, 1'b1);
    chk_b("wrap_done_nowr", tbl_write, 1'b0);
    tick();
    chk_b("wrap_idle", busy, 1'b0);

    // Type mismatch on the second word: slot base+1 skipped
    do_start(3'd2, 4'd3, 2'b01);
    in_valid = 1'b1;
    in_data  = mk(2'b01, 400);
    tick();
    chk_wr("mm_w0", 3'd2, mk(2'b01, 400));
    chk_b("mm_err0", err, 1'b0);
    in_data = mk(2'b10, 401);
    tick();
    chk_b("mm_skip_wr", tbl_write, 1'b0);
    chk_i("mm_skip_idx", tbl_idx, 3'd2);
    chk_b("mm_err1", err, 1'b1);
    in_data = mk(2'b01, 402);
    tick();
    chk_wr("mm_w2", 3'd4, mk(2'b01, 402));
    in_valid = 1'b0;
    tick();
    chk_b("mm_done", done, 1'b1);
    chk_b("mm_err_done", err, 1'b1);
    tick();
    chk_b("mm_idle", busy, 1'b0);
    chk_b("mm_err_sticky", err, 1'b1);

    // count 0: done next cycle, err cleared by the start
    chk_b("c0_ready_pre", in_ready, 1'b0);
    do_start(3'd7, 4'd0, 2'b00);
    chk_b("c0_done", done, 1'b1);
    chk_b("c0_busy", busy, 1'b1);
    chk_b("c0_err_clr", err, 1'b0);
    chk_b("c0_ready", in_ready, 1'b0);
    chk_b("c0_nowr", tbl_write, 1'b0);
    tick();
    chk_b("c0_done_pulse", done, 1'b0);
    chk_b("c0_idle", busy, 1'b0);
    chk_b("c0_ready_post", in_ready, 1'b0);

    // count 15 clamps to 8; a start mid-burst is ignored
    do_start(3'd5, 4'd15, 2'b00);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = mk(2'b00, 200 + i);
      if (i == 3) begin
        start = 1'b1; base_idx = 3'd0; count = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk_wr($sformatf("clamp_w%0d", i), 3'(5 + i), mk(2'b00, 200 + i));
    end
    start   = 1'b0;
    in_data = mk(2'b00, 300);
    chk_b("clamp_ready_drop", in_ready, 1'b0);
    tick();
    chk_b("clamp_no9th", tbl_write, 1'b0);
    chk_b("clamp_done", done, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_b("clamp_idle", busy, 1'b0);
    chk_b("clamp_done_pulse", done, 1'b0);

    // Reset after 2 of 5 accepts aborts the burst
    do_start(3'd1, 4'd5, 2'b10);
    in_valid = 1'b1;
    in_data  = mk(2'b10, 500);
    tick();
    chk_wr("ra_w0", 3'd1, mk(2'b10, 500));
    in_data = mk(2'b10, 501);
    tick();
    chk_wr("ra_w1", 3'd2, mk(2'b10, 501));
    in_data = mk(2'b10, 502);
    rst = 1'b1;
    tick();
    chk_reset_vals("ra_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b($sformatf("ra_post%0d_wr", i), tbl_write, 1'b0);
      chk_b($sformatf("ra_post%0d_done", i), done, 1'b0);
      chk_b($sformatf("ra_post%0d_ready", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    do_start(3'd3, 4'd1, 2'b10);
    in_valid = 1'b1;
    in_data  = mk(2'b10, 600);
    tick();
    chk_wr("ra_new_w0", 3'd3, mk(2'b10, 600));
    in_valid = 1'b0;
    tick();
    chk_b("ra_new_done", done, 1'b1);
    chk_b("ra_new_err", err, 1'b0);
    tick();
    chk_b("ra_new_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
